// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory,
// applies delayed jump/branch redirects and feeds ID plus the forwarding history.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        jump_del,
  input  logic        branch_del,
  input  logic        branch_taken,
  input  logic [25:0] target_inst,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  output logic [31:0] instruction,
  output logic [31:0] id_pc4,
  output logic [31:0] ex_int_forward,
  output logic [31:0] mem_int_forward
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_inc;
  logic [31:0] pend_pc, pend_nxt;
  logic [31:0] skid, skid_pc4;
  logic        skid_load;
  logic        new_vld;
  logic [31:0] new_word, new_pc4;
  logic        is_j, is_jr, is_b, redirect;
  logic [31:0] id_pc, j_target, target, target_al;

  // The j page comes from the delay-slot address itself, not from id_pc4,
  // so a delay slot at the last word of a 256 MB page stays in that page.
  assign id_pc     = id_pc4 - 32'd4;
  assign j_target  = (id_pc & 32'hF000_0000) | {4'b0000, target_inst, 2'b00};
  assign is_j      = jump_del & ~branch_del;
  assign is_jr     = jump_del & branch_del;
  assign is_b      = branch_del & ~jump_del & branch_taken;
  assign redirect  = is_j | is_jr | is_b;
  assign target    = is_jr ? jr_target : (is_b ? branch_target : j_target);
  assign target_al = target & 32'hFFFF_FFFC;
  assign pc_inc    = pc + 32'd4;
  assign imem_addr = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_pc;
    skid_load = 1'b0;
    new_vld   = 1'b0;
    new_word  = imem_rdata;
    new_pc4   = pc_inc;
    imem_req  = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (redirect) begin
            pc_nxt = target_al;
          end else begin
            pc_nxt = pc_inc;
            if (stall) begin
              skid_load = 1'b1;
              state_nxt = HOLD;
            end else begin
              new_vld = 1'b1;
            end
          end
        end else if (redirect) begin
          pend_nxt  = target_al;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The outstanding request must complete before the new PC can be issued.
        imem_req = 1'b1;
        if (redirect) pend_nxt = target_al;
        if (imem_ack) begin
          pc_nxt    = redirect ? target_al : pend_pc;
          state_nxt = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt    = target_al;
          state_nxt = FETCH;
        end else if (!stall) begin
          new_vld   = 1'b1;
          new_word  = skid;
          new_pc4   = skid_pc4;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      pend_pc  <= RESET_PC;
      skid     <= BUBBLE;
      skid_pc4 <= RESET_PC + 32'd4;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_nxt;
      if (skid_load) begin
        skid     <= imem_rdata;
        skid_pc4 <= pc_inc;
      end
    end
  end

  // Instruction pipeline: ID, then one and two slots older for forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction     <= BUBBLE;
      id_pc4          <= RESET_PC + 32'd4;
      ex_int_forward  <= BUBBLE;
      mem_int_forward <= BUBBLE;
    end else begin
      mem_int_forward <= ex_int_forward;
      if (stall) begin
        ex_int_forward <= BUBBLE;
      end else begin
        ex_int_forward <= instruction;
        instruction    <= new_vld ? new_word : BUBBLE;
        if (new_vld) id_pc4 <= new_pc4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: every word the bench expects in ID is queued
// when it is acked and compared when it appears on instruction/id_pc4.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = 32'hDEAD_BEE1;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        jump_del = 1'b0;
  logic        branch_del = 1'b0;
  logic        branch_taken = 1'b0;
  logic [25:0] target_inst = 26'h0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] instruction, id_pc4, ex_int_forward, mem_int_forward;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .BUBBLE(BUBBLE)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .stall(stall), .jump_del(jump_del), .branch_del(branch_del),
    .branch_taken(branch_taken), .target_inst(target_inst),
    .branch_target(branch_target), .jr_target(jr_target),
    .instruction(instruction), .id_pc4(id_pc4),
    .ex_int_forward(ex_int_forward), .mem_int_forward(mem_int_forward)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc4;
  } id_exp_t;

  id_exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0004: return 32'h0043_2023;
      default:       return a ^ 32'hC0DE_0001;
    endcase
  endfunction

  // Acknowledge the current request; the address is checked against the bench's own PC.
  task automatic ack_word(input logic [31:0] a, input bit push);
    check("imem_addr", imem_addr, a);
    check("imem_req", {31'b0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = mem_word(a);
    if (push) sb_q.push_back('{mem_word(a), a + 32'd4});
  endtask

  task automatic tick();
    logic    s;
    id_exp_t e;
    s = stall;
    @(posedge clk);
    #1;
    if (!s && rst && instruction !== BUBBLE) begin
      if (sb_q.size() == 0) begin
        check("id_unexpected", instruction, BUBBLE);
      end else begin
        e = sb_q.pop_front();
        check("id_word", instruction, e.word);
        check("id_pc4", id_pc4, e.pc4);
      end
    end
    imem_ack     = 1'b0;
    imem_rdata   = 32'hDEAD_BEE1;
    stall        = 1'b0;
    jump_del     = 1'b0;
    branch_del   = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_inst", instruction, BUBBLE);
    check("rst_ex", ex_int_forward, BUBBLE);
    check("rst_mem", mem_int_forward, BUBBLE);
    check("rst_pc4", id_pc4, RESET_PC + 32'd4);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("boot_req", {31'b0, imem_req}, 32'd0);
    tick();
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RESET_PC);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Zero-wait memory: one word per cycle, mem_int_forward three cycles after ack.
    for (int k = 0; k < 6; k++) begin
      if (k == 3) check("mem_fwd_word0", mem_int_forward, mem_word(32'h0));
      ack_word(32'(4 * k), 1'b1);
      tick();
    end

    // Two wait states per word: address and request held, bubbles into ID.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 2; w++) begin
        check("wait_addr", imem_addr, 32'(24 + 4 * k));
        check("wait_req", {31'b0, imem_req}, 32'd1);
        tick();
        check("wait_bubble", instruction, BUBBLE);
      end
      ack_word(32'(24 + 4 * k), 1'b1);
      tick();
    end

    // j with a concurrent ack: acked word dropped, delay slot moves on to EX.
    ack_word(32'h20, 1'b0);
    jump_del    = 1'b1;
    target_inst = 26'h10;
    tick();
    check("j_addr", imem_addr, 32'h0000_0040);
    check("j_squash", instruction, BUBBLE);
    check("j_delay_slot", ex_int_forward, mem_word(32'h1C));
    ack_word(32'h40, 1'b1);
    tick();

    // jr while the request is still waiting: DRAIN, stale ack dropped.
    jump_del   = 1'b1;
    branch_del = 1'b1;
    jr_target  = 32'h0000_0102;
    tick();
    check("drain_addr", imem_addr, 32'h44);
    check("drain_req", {31'b0, imem_req}, 32'd1);
    tick();
    check("drain_addr2", imem_addr, 32'h44);
    ack_word(32'h44, 1'b0);
    tick();
    check("jr_addr", imem_addr, 32'h0000_0100);
    ack_word(32'h100, 1'b1);
    tick();

    // Stall for three cycles with the ack in the first: skid holds the word.
    ack_word(32'h104, 1'b1);
    stall = 1'b1;
    tick();
    check("hold_req", {31'b0, imem_req}, 32'd0);
    check("hold_id", instruction, mem_word(32'h100));
    check("hold_ex1", ex_int_forward, BUBBLE);
    for (int c = 0; c < 2; c++) begin
      stall = 1'b1;
      tick();
      check("hold_ex", ex_int_forward, BUBBLE);
      check("hold_req2", {31'b0, imem_req}, 32'd0);
    end
    tick();
    check("unhold_ex", ex_int_forward, mem_word(32'h100));
    check("unhold_addr", imem_addr, 32'h108);
    check("unhold_req", {31'b0, imem_req}, 32'd1);

    // Untaken bltz is sequential; taken bltz to the top word, then wrap to 0.
    ack_word(32'h108, 1'b1);
    branch_del    = 1'b1;
    branch_target = 32'h0000_0200;
    tick();
    check("bltz_nt_addr", imem_addr, 32'h10C);
    ack_word(32'h10C, 1'b0);
    branch_del    = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    tick();
    check("bltz_t_addr", imem_addr, 32'hFFFF_FFFC);
    ack_word(32'hFFFF_FFFC, 1'b1);
    tick();
    check("wrap_addr", imem_addr, 32'h0);

    // Redirect during HOLD with stall still high: skid discarded, ID held.
    // The j page comes from id_pc4-4 (0xFFFF_FFFC), not id_pc4 (0).
    ack_word(32'h0, 1'b0);
    stall = 1'b1;
    tick();
    jump_del    = 1'b1;
    target_inst = 26'h123;
    stall       = 1'b1;
    tick();
    check("hold_j_addr", imem_addr, 32'hF000_048C);
    check("hold_j_id", instruction, mem_word(32'hFFFF_FFFC));
    check("hold_j_ex", ex_int_forward, BUBBLE);
    ack_word(32'hF000_048C, 1'b1);
    tick();

    // Reset in the middle of HOLD.
    ack_word(32'hF000_0490, 1'b1);
    stall = 1'b1;
    tick();
    do_reset();
    ack_word(32'h0, 1'b1);
    tick();
    ack_word(32'h4, 1'b1);
    tick();

    // Reset in the middle of DRAIN: the pending target must be forgotten.
    jump_del   = 1'b1;
    branch_del = 1'b1;
    jr_target  = 32'h0000_0300;
    tick();
    do_reset();
    ack_word(32'h0, 1'b1);
    tick();
    check("post_drain_addr", imem_addr, 32'h4);
    tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
